// File: rtl/bp_fe_bp_two_level_local_v2_if.sv
// Request/response bundle between the front end and the two-level local branch predictor.
// master drives read/update requests; slave is the predictor.
interface bp_fe_bp_two_level_local_v2_if #(
  parameter int bht_idx_width_p = 4
);
  logic                       ready_o;
  logic                       r_v_i;
  logic [bht_idx_width_p-1:0] idx_r_i;
  logic                       predict_v_o;
  logic                       predict_o;
  logic                       w_v_i;
  logic [bht_idx_width_p-1:0] idx_w_i;
  logic                       taken_i;

  modport master (
    input  ready_o, predict_v_o, predict_o,
    output r_v_i, idx_r_i, w_v_i, idx_w_i, taken_i
  );

  modport slave (
    output ready_o, predict_v_o, predict_o,
    input  r_v_i, idx_r_i, w_v_i, idx_w_i, taken_i
  );
endinterface

// File: rtl/bp_fe_bp_two_level_local_v2.sv
// Two-level local branch predictor: per-branch history (BHT) indexes saturating counters (PHT).
// Optional perf counters enabled by defining BP_FE_BP_TWO_LEVEL_LOCAL_PERF_EN.
module bp_fe_bp_two_level_local_v2 #(
  parameter int bht_idx_width_p   = 4,
  parameter int bp_n_hist_p       = 4,
  parameter int pht_idx_width_p   = 4,
  parameter int bp_cnt_sat_bits_p = 2,
  parameter int hash_mode_p       = 0
) (
  input  logic clk_i,
  input  logic reset_i,
  bp_fe_bp_two_level_local_v2_if.slave bp
`ifdef BP_FE_BP_TWO_LEVEL_LOCAL_PERF_EN
  ,
  output logic [31:0] perf_upd_o,
  output logic [31:0] perf_mispred_o
`endif
);

  localparam int bht_depth_lp = 1 << bht_idx_width_p;
  localparam int pht_depth_lp = 1 << pht_idx_width_p;
  localparam int d_lp         = (bht_depth_lp > pht_depth_lp) ? bht_depth_lp : pht_depth_lp;
  localparam int cnt_w_lp     = $clog2(d_lp);

  typedef logic [bp_n_hist_p-1:0]       hist_t;
  typedef logic [bp_cnt_sat_bits_p-1:0] ctr_t;
  typedef logic [pht_idx_width_p-1:0]   pidx_t;
  typedef logic [bht_idx_width_p-1:0]   bidx_t;
  typedef logic [cnt_w_lp-1:0]          cnt_t;

  localparam ctr_t wnt_lp     = ctr_t'((1 << (bp_cnt_sat_bits_p - 1)) - 1);
  localparam ctr_t ctr_max_lp = {bp_cnt_sat_bits_p{1'b1}};

  typedef enum logic {
    e_init,
    e_ready
  } state_e;

  state_e state_q, state_d;
  cnt_t   cnt_q, cnt_d;

  hist_t bht_mem [bht_depth_lp];
  ctr_t  pht_mem [pht_depth_lp];

  // Branch index zero-extended (or truncated) into the PHT index space before the XOR.
  function automatic pidx_t pht_index(input hist_t hist, input bidx_t idx);
    logic [bht_idx_width_p+pht_idx_width_p-1:0] idx_ext;
    idx_ext   = {{pht_idx_width_p{1'b0}}, idx};
    pht_index = hist[pht_idx_width_p-1:0];
    if (hash_mode_p == 1) pht_index = pht_index ^ idx_ext[pht_idx_width_p-1:0];
  endfunction

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      e_init: begin
        cnt_d = cnt_q + cnt_t'(1);
        if (cnt_q == cnt_t'(d_lp - 1)) state_d = e_ready;
      end
      e_ready: state_d = e_ready;
      default: state_d = e_init;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= e_init;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  logic ready;
  logic init_bht, init_pht;
  assign ready    = (state_q == e_ready);
  assign init_bht = ({1'b0, cnt_q} < (cnt_w_lp + 1)'(bht_depth_lp));
  assign init_pht = ({1'b0, cnt_q} < (cnt_w_lp + 1)'(pht_depth_lp));

  // Read path: both lookups are combinational from pre-edge table contents.
  pidx_t rd_pidx;
  logic  rd_taken;
  assign rd_pidx  = pht_index(bht_mem[bp.idx_r_i], bp.idx_r_i);
  assign rd_taken = (pht_mem[rd_pidx] > wnt_lp);

  // Update path: PHT index uses the history before the shift.
  hist_t wr_hist;
  pidx_t wr_pidx;
  ctr_t  wr_ctr, ctr_next;
  logic  wr_pred, upd_v;
  assign wr_hist = bht_mem[bp.idx_w_i];
  assign wr_pidx = pht_index(wr_hist, bp.idx_w_i);
  assign wr_ctr  = pht_mem[wr_pidx];
  assign wr_pred = (wr_ctr > wnt_lp);
  assign upd_v   = ready & bp.w_v_i;

  always_comb begin
    ctr_next = wr_ctr;
    if (bp.taken_i && (wr_ctr != ctr_max_lp))   ctr_next = wr_ctr + ctr_t'(1);
    else if (!bp.taken_i && (wr_ctr != '0))      ctr_next = wr_ctr - ctr_t'(1);
  end

  // NOTE: the tables have no reset; the INIT sweep clears them, letting them map to plain RAM.
  always_ff @(posedge clk_i) begin
    if (state_q == e_init) begin
      if (init_bht) bht_mem[cnt_q[bht_idx_width_p-1:0]] <= '0;
      if (init_pht) pht_mem[cnt_q[pht_idx_width_p-1:0]] <= wnt_lp;
    end else if (upd_v) begin
      bht_mem[bp.idx_w_i] <= {wr_hist[bp_n_hist_p-2:0], bp.taken_i};
      pht_mem[wr_pidx]    <= ctr_next;
    end
  end

  logic predict_v_q, predict_q;
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      predict_v_q <= 1'b0;
      predict_q   <= 1'b0;
    end else begin
      predict_v_q <= ready & bp.r_v_i;
      predict_q   <= ready & bp.r_v_i & rd_taken;
    end
  end

  assign bp.ready_o     = ready;
  assign bp.predict_v_o = predict_v_q;
  assign bp.predict_o   = predict_q;

`ifdef BP_FE_BP_TWO_LEVEL_LOCAL_PERF_EN
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      perf_upd_o     <= '0;
      perf_mispred_o <= '0;
    end else if (upd_v) begin
      if (perf_upd_o != '1) perf_upd_o <= perf_upd_o + 32'd1;
      if ((wr_pred != bp.taken_i) && (perf_mispred_o != '1))
        perf_mispred_o <= perf_mispred_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/bp_fe_bp_two_level_local_v2.md
Name: bp_fe_bp_two_level_local_v2

Overview:
Parametrised successor of the two-level local branch predictor in the front end. Level 1 is a per-branch history table (BHT) of shift registers; level 2 is a pattern history table (PHT) of saturating counters. It adds a selectable PHT index hash, a registered read path, an explicit taken_i update, and an init state machine that clears the tables after reset, so the arrays carry no reset.

Parameters:
bht_idx_width_p, 4, BHT index width; BHT depth = 2**bht_idx_width_p
bp_n_hist_p, 4, history bits per BHT entry (>=2)
pht_idx_width_p, 4, PHT index width; PHT depth = 2**pht_idx_width_p; must be <= bp_n_hist_p
bp_cnt_sat_bits_p, 2, counter width (>=2)
hash_mode_p, 0, 0 = history only; 1 = history XOR branch index

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous, active-low reset
ready_o  out  1  init done; requests are accepted only when 1
r_v_i  in  1  prediction request
idx_r_i  in  bht_idx_width_p  read branch index
predict_v_o  out  1  prediction valid, 1 cycle after an accepted r_v_i
predict_o  out  1  1 = taken; 0 whenever predict_v_o = 0
w_v_i  in  1  resolved-branch update
idx_w_i  in  bht_idx_width_p  update branch index
taken_i  in  1  actual branch outcome

Behaviour:
- Derived values:
  - D = max(BHT depth, PHT depth).
  - WNT = 2**(bp_cnt_sat_bits_p-1)-1, the weakly-not-taken value.
  - Prediction is taken when the counter > WNT.
- PHT index for entry i:
  - hash 0: bht[i][pht_idx_width_p-1:0].
  - hash 1: that value XOR i, with i zero-extended or truncated to pht_idx_width_p.
- State machine INIT -> READY:
  - Async reset (reset_i = 0): state = INIT, init counter = 0, ready_o = 0, predict_v_o = 0, predict_o = 0, all immediately.
  - INIT, each cycle after reset release: write bht[cnt] = 0 if cnt < BHT depth; write pht[cnt] = WNT if cnt < PHT depth; then cnt++.
  - INIT -> READY after the write at cnt = D-1. ready_o = 1 from the following cycle. INIT lasts exactly D cycles.
  - READY is held until the next reset.
  - Asserting reset mid-INIT or mid-READY restarts the sweep from 0.
- Requests while ready_o = 0:
  - r_v_i and w_v_i are ignored; no state change.
  - predict_v_o stays 0.
- Read (READY):
  - Index computed combinationally from bht[idx_r_i]; outcome registered.
  - predict_v_o = 1 and predict_o valid in the cycle after r_v_i.
  - No r_v_i -> predict_v_o = 0 and predict_o = 0 next cycle.
- Update (READY, w_v_i = 1), both writes take effect at the clock edge:
  - p = PHT index of bht[idx_w_i], computed before the shift.
  - bht[idx_w_i] <= {bht[idx_w_i][bp_n_hist_p-2:0], taken_i}.
  - taken_i = 1: pht[p] increments, saturating at all-ones.
  - taken_i = 0: pht[p] decrements, saturating at 0.
- Simultaneous read and update: read sees pre-update BHT and PHT values (read-before-write), including when idx_r_i == idx_w_i or the PHT indices collide.
- Single update port: at most one BHT entry and one PHT entry change per cycle.

Optional Feature:
BP_FE_BP_TWO_LEVEL_LOCAL_PERF_EN
- Defined: adds outputs perf_upd_o (32 bits, accepted updates) and perf_mispred_o (32 bits).
  - perf_mispred_o increments when the pre-update prediction for idx_w_i != taken_i.
  - Both counters saturate at 2**32-1 and clear on reset.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan (default parameters, D = 16, WNT = 1):
1. Release reset; hold r_v_i = 1 throughout -> ready_o = 0 for 16 cycles, then 1. predict_v_o = 0 throughout INIT; first read then returns predict_o = 0.
2. Three not-taken updates to idx 3 -> pht[0] goes 1->0->0 (saturates). Read idx 3 -> 0. One taken update to idx 3 -> pht[0] = 1, bht[3] = 0001. Read idx 7 -> 0.
3. Fresh init; taken update to idx 2 -> pht[0] = 2. Read idx 5 the next cycle -> predict_v_o = 1 and predict_o = 1 exactly one cycle after r_v_i.
4. Fresh init; same cycle w_v_i (idx 2, taken) and r_v_i (idx 2) -> predict_o = 0 (pre-update). Read idx 2 again -> uses bht[2] = 0001 and pht[1] = 1 -> 0.
5. hash_mode_p = 1: taken updates to idx 4 and idx 5 (both hist 0) -> pht[4] = 2 and pht[5] = 2; reads of idx 4 and idx 6 -> 1 and 0.
6. Drive reset_i low mid-stream with r_v_i = 1 -> ready_o and predict_v_o drop the same cycle. After release: 16-cycle re-init, then read idx 2 -> 0 (tables cleared). With PERF_EN defined, perf counters read 0.
